// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and its iterative multiply/divide unit.
package alu_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_NOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_MULTU = 4'd6,
        ALU_DIVU  = 4'd7,
        ALU_MFHI  = 4'd8,
        ALU_MFLO  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_op_e;

endpackage

// File: rtl/alu_muldiv_exec_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit with HI/LO result registers.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  md_op_e       op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          done_q, done_d;

    logic [W:0]    mul_sum_s;
    logic [W-1:0]  mul_acc_s;
    logic [W-1:0]  mul_q_s;
    logic [W:0]    div_sh_s;
    logic          div_ge_s;
    logic [W-1:0]  div_acc_s;
    logic [W-1:0]  div_q_s;

    // One iteration step of each algorithm, plus FSM next-state and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        // {acc,q} holds the partial product; the multiplier bit is consumed from q[0].
        mul_sum_s = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
        mul_acc_s = mul_sum_s[W:1];
        mul_q_s   = {mul_sum_s[0], q_q[W-1:1]};

        // acc < b invariant keeps the shifted remainder within W+1 bits; b=0 yields all-ones quotient.
        div_sh_s  = {acc_q, q_q[W-1]};
        div_ge_s  = (div_sh_s >= {1'b0, b_q});
        div_acc_s = div_ge_s ? (div_sh_s[W-1:0] - b_q) : div_sh_s[W-1:0];
        div_q_s   = {q_q[W-2:0], div_ge_s};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (op == MD_DIV) ? ST_DIV : ST_MUL;
                    cnt_d   = CW'(W);
                    acc_d   = {W{1'b0}};
                    q_d     = a;
                    b_d     = b;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d = mul_acc_s;
                q_d   = mul_q_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = mul_acc_s;
                    lo_d    = mul_q_s;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DIV: begin
                acc_d = div_acc_s;
                q_d   = div_q_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = div_acc_s;
                    lo_d    = div_q_s;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DIV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any iteration and clears HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            acc_q   <= {W{1'b0}};
            q_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            hi_q    <= {W{1'b0}};
            lo_q    <= {W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_muldiv_exec.sv
// EX-stage execute unit: combinational ALU with control decode plus an iterative mul/div unit.
module alu_muldiv_exec
    import alu_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   ALUop,
    input  logic         ALUSrc,
    input  logic         Issue,
    input  logic [W-1:0] RD1,
    input  logic [W-1:0] RD2,
    input  logic [W-1:0] SE,
    output logic [W-1:0] Out,
    output logic [W-1:0] Out2,
    output logic         Zero,
    output logic         Busy,
    output logic         Done,
    output logic         Stall
);

    alu_op_e      alu_op_s;
    logic [W-1:0] b_s;
    logic [W-1:0] out_s;
    logic         is_md_s;
    logic         is_mv_s;
    logic         start_s;
    logic         busy_s;
    logic         done_s;
    logic [W-1:0] hi_s;
    logic [W-1:0] lo_s;
    md_op_e       md_op_s;

    // ALU control decode from ALUop and the funct field.
    always_comb begin
        alu_op_s = ALU_ADD;
        case (aluop_e'(ALUop))
            ALUOP_ADD: alu_op_s = ALU_ADD;
            ALUOP_SUB: alu_op_s = ALU_SUB;
            ALUOP_OR:  alu_op_s = ALU_OR;
            ALUOP_RTYPE: begin
                case (SE[5:0])
                    FN_ADD:   alu_op_s = ALU_ADD;
                    FN_SUB:   alu_op_s = ALU_SUB;
                    FN_AND:   alu_op_s = ALU_AND;
                    FN_OR:    alu_op_s = ALU_OR;
                    FN_NOR:   alu_op_s = ALU_NOR;
                    FN_SLT:   alu_op_s = ALU_SLT;
                    FN_MULTU: alu_op_s = ALU_MULTU;
                    FN_DIVU:  alu_op_s = ALU_DIVU;
                    FN_MFHI:  alu_op_s = ALU_MFHI;
                    FN_MFLO:  alu_op_s = ALU_MFLO;
                    default:  alu_op_s = ALU_ADD;
                endcase
            end
            default: alu_op_s = ALU_ADD;
        endcase
    end

    assign b_s     = ALUSrc ? SE : RD2;
    assign is_md_s = (alu_op_s == ALU_MULTU) || (alu_op_s == ALU_DIVU);
    assign is_mv_s = (alu_op_s == ALU_MFHI) || (alu_op_s == ALU_MFLO);
    assign md_op_s = (alu_op_s == ALU_DIVU) ? MD_DIV : MD_MUL;
    assign start_s = Issue & is_md_s & ~busy_s;

    // Result mux; mul/div themselves drive zero, moves return HI/LO even while stale.
    always_comb begin
        out_s = {W{1'b0}};
        case (alu_op_s)
            ALU_ADD:   out_s = RD1 + b_s;
            ALU_SUB:   out_s = RD1 - b_s;
            ALU_AND:   out_s = RD1 & b_s;
            ALU_OR:    out_s = RD1 | b_s;
            ALU_NOR:   out_s = ~(RD1 | b_s);
            ALU_SLT:   out_s = ($signed(RD1) < $signed(b_s)) ? {{(W-1){1'b0}}, 1'b1} : {W{1'b0}};
            ALU_MFHI:  out_s = hi_s;
            ALU_MFLO:  out_s = lo_s;
            ALU_MULTU: out_s = {W{1'b0}};
            ALU_DIVU:  out_s = {W{1'b0}};
            default:   out_s = {W{1'b0}};
        endcase
    end

    muldiv_iter #(
        .W  (W),
        .CW (CW)
    ) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .op    (md_op_s),
        .a     (RD1),
        .b     (RD2),
        .busy  (busy_s),
        .done  (done_s),
        .hi    (hi_s),
        .lo    (lo_s)
    );

    assign Out   = out_s;
    assign Out2  = RD2;
    assign Zero  = (out_s == {W{1'b0}});
    assign Busy  = busy_s;
    assign Done  = done_s;
    assign Stall = Issue & busy_s & (is_md_s | is_mv_s);

endmodule

// File: tb/tb_alu_muldiv_exec.sv
// Directed bench: table of combinational ALU vectors plus hand-written mul/div sequences.
module tb_alu_muldiv_exec;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic        clk;
    logic        reset;
    logic [1:0]  ALUop;
    logic        ALUSrc;
    logic        Issue;
    logic [31:0] RD1, RD2, SE;
    logic [31:0] Out, Out2;
    logic        Zero, Busy, Done, Stall;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    typedef struct {
        string       name;
        logic [1:0]  aluop;
        logic        alusrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] se;
        logic [31:0] exp_out;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[11];

    alu_muldiv_exec #(.W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .ALUop  (ALUop),
        .ALUSrc (ALUSrc),
        .Issue  (Issue),
        .RD1    (RD1),
        .RD2    (RD2),
        .SE     (SE),
        .Out    (Out),
        .Out2   (Out2),
        .Zero   (Zero),
        .Busy   (Busy),
        .Done   (Done),
        .Stall  (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a mul/div op; returns just after the edge that accepts it.
    task automatic start_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        ALUop  = 2'b10;
        ALUSrc = 1'b0;
        SE     = {26'd0, fn};
        RD1    = a;
        RD2    = b;
        Issue  = 1'b1;
        #1;
        chk("md_issue_out", Out, 32'd0);
        chk("md_issue_stall", {31'd0, Stall}, 32'd0);
        tick();
    endtask

    task automatic wait_done(output int n, input bit chk_stall);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            if (chk_stall) chk("stall_while_busy", {31'd0, Stall}, 32'd1);
            n++;
            tick();
        end
    endtask

    task automatic read_hilo(input string nm, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        ALUop = 2'b10;
        Issue = 1'b1;
        SE    = {26'd0, F_MFHI};
        #1;
        chk({nm, "_hi"}, Out, exp_hi);
        SE    = {26'd0, F_MFLO};
        #1;
        chk({nm, "_lo"}, Out, exp_lo);
        Issue = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"r_add",  2'b10, 1'b0, 32'd5, 32'd6, {26'd0, F_ADD}, 32'd11,        1'b0};
        vecs[1]  = '{"r_sub",  2'b10, 1'b0, 32'd5, 32'd6, {26'd0, F_SUB}, 32'hFFFFFFFF,  1'b0};
        vecs[2]  = '{"r_and",  2'b10, 1'b0, 32'd5, 32'd6, {26'd0, F_AND}, 32'd4,         1'b0};
        vecs[3]  = '{"r_or",   2'b10, 1'b0, 32'd5, 32'd6, {26'd0, F_OR},  32'd7,         1'b0};
        vecs[4]  = '{"r_slt",  2'b10, 1'b0, 32'd5, 32'd6, {26'd0, F_SLT}, 32'd1,         1'b0};
        vecs[5]  = '{"r_nor",  2'b10, 1'b0, 32'd5, 32'd6, {26'd0, F_NOR}, 32'hFFFFFFF8,  1'b0};
        vecs[6]  = '{"beq_sub", 2'b01, 1'b0, 32'd9, 32'd9, 32'd0,          32'd0,         1'b1};
        vecs[7]  = '{"lw_add", 2'b00, 1'b1, 32'd100, 32'd6, 32'hFFFFFFFC,  32'd96,        1'b0};
        vecs[8]  = '{"ori",    2'b11, 1'b1, 32'd5, 32'd6, 32'h00000030,   32'h00000035,  1'b0};
        vecs[9]  = '{"slt_neg", 2'b10, 1'b0, 32'hFFFFFFFF, 32'd1, {26'd0, F_SLT}, 32'd1,  1'b0};
        vecs[10] = '{"slt_pos", 2'b10, 1'b0, 32'd1, 32'hFFFFFFFF, {26'd0, F_SLT}, 32'd0,  1'b1};

        reset = 1'b1; ALUop = 2'b00; ALUSrc = 1'b0; Issue = 1'b0;
        RD1 = 32'd0; RD2 = 32'd0; SE = 32'd0;
        repeat (2) tick();
        chk("rst_out", Out, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd1);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        reset = 1'b0;
        tick();
        read_hilo("rst", 32'd0, 32'd0);

        for (int i = 0; i < 11; i++) begin
            ALUop  = vecs[i].aluop;
            ALUSrc = vecs[i].alusrc;
            RD1    = vecs[i].rd1;
            RD2    = vecs[i].rd2;
            SE     = vecs[i].se;
            Issue  = 1'b1;
            #2;
            chk({vecs[i].name, "_out"}, Out, vecs[i].exp_out);
            chk({vecs[i].name, "_zero"}, {31'd0, Zero}, {31'd0, vecs[i].exp_zero});
            chk({vecs[i].name, "_out2"}, Out2, vecs[i].rd2);
            chk({vecs[i].name, "_stall"}, {31'd0, Stall}, 32'd0);
        end
        Issue = 1'b0;
        tick();

        // multu with mfhi held during the busy window
        start_md(F_MULTU, 32'h00010000, 32'h00010000);
        SE = {26'd0, F_MFHI};
        #1;
        chk("mul_busy_first", {31'd0, Busy}, 32'd1);
        chk("mfhi_stale", Out, 32'd0);
        wait_done(cyc, 1'b1);
        chk("mul_busy_cycles", cyc, 32'd32);
        chk("mul_done", {31'd0, Done}, 32'd1);
        chk("mul_done_stall", {31'd0, Stall}, 32'd0);
        chk("mul_done_mfhi", Out, 32'd1);
        Issue = 1'b0;
        tick();
        chk("mul_done_pulse", {31'd0, Done}, 32'd0);
        read_hilo("mul", 32'd1, 32'd0);

        start_md(F_DIVU, 32'd100, 32'd7);
        Issue = 1'b0;
        wait_done(cyc, 1'b0);
        chk("div_cycles", cyc, 32'd32);
        chk("div_done", {31'd0, Done}, 32'd1);
        read_hilo("div", 32'd2, 32'd14);
        tick();

        start_md(F_DIVU, 32'd100, 32'd0);
        Issue = 1'b0;
        wait_done(cyc, 1'b0);
        chk("div0_cycles", cyc, 32'd32);
        read_hilo("div0", 32'd100, 32'hFFFFFFFF);
        tick();

        // second op held at Issue while the first is busy
        start_md(F_DIVU, 32'd100, 32'd7);
        RD1 = 32'd3; RD2 = 32'd4; SE = {26'd0, F_MULTU}; Issue = 1'b1;
        #1;
        wait_done(cyc, 1'b1);
        chk("b2b_first_cycles", cyc, 32'd32);
        chk("b2b_done", {31'd0, Done}, 32'd1);
        chk("b2b_accept_stall", {31'd0, Stall}, 32'd0);
        tick();
        SE = {26'd0, F_MFLO};
        #1;
        chk("b2b_second_busy", {31'd0, Busy}, 32'd1);
        chk("b2b_mflo_stall", {31'd0, Stall}, 32'd1);
        chk("b2b_mflo_stale", Out, 32'd14);
        wait_done(cyc, 1'b1);
        chk("b2b_second_cycles", cyc, 32'd32);
        read_hilo("b2b", 32'd0, 32'd12);
        tick();

        // reset in the middle of an iteration
        start_md(F_MULTU, 32'h00010000, 32'h00010000);
        Issue = 1'b0;
        repeat (9) tick();
        chk("rst_mid_busy_before", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
        chk("rst_mid_done", {31'd0, Done}, 32'd0);
        read_hilo("rst_mid", 32'd0, 32'd0);
        tick();
        chk("rst_mid_no_done", {31'd0, Done}, 32'd0);
        start_md(F_MULTU, 32'd2, 32'd3);
        Issue = 1'b0;
        wait_done(cyc, 1'b0);
        chk("post_rst_cycles", cyc, 32'd32);
        read_hilo("post_rst", 32'd0, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_exec.md
Name: alu_muldiv_exec

Overview:
- Parametrised successor to the single-cycle ALU/ALU-control execute stage of the CPU.
- Keeps the combinational integer ALU and its control decode: ALUop plus the funct field taken from SE[5:0].
- Adds an iterative unsigned multiply/divide unit with HI/LO registers, a start/busy/done handshake and a stall output for the pipeline.
- Sits in the EX stage, between the register-file read ports and the EX/MEM register.

Parameters:
- W, 32: datapath width in bits (W >= 8).
- CW, $clog2(W+1): iteration counter width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ALUop  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type (decode funct), 11 or (ori).
- ALUSrc  in  1  operand B select: 1 = SE, 0 = RD2.
- Issue  in  1  instruction in EX is valid this cycle.
- RD1  in  W  operand A.
- RD2  in  W  operand B / store data.
- SE  in  W  sign-extended immediate; SE[5:0] is funct.
- Out  out  W  ALU result or HI/LO move result.
- Out2  out  W  RD2 passthrough (store data).
- Zero  out  1  Out == 0.
- Busy  out  1  mul/div iteration in progress.
- Done  out  1  one-cycle pulse when HI/LO are updated.
- Stall  out  1  pipeline must hold EX this cycle.

Behaviour:
- Funct decode (ALUop=10):
  - 100000 add; 100010 sub; 100100 and; 100101 or; 100111 nor; 101010 slt (signed, result 0 or 1).
  - 011001 multu; 011011 divu; 010000 mfhi; 010010 mflo.
  - Any other funct: add.
- Combinational ops (add/sub/and/or/nor/slt):
  - Out, Zero and Out2 are combinational from inputs, zero-cycle latency.
  - Results are modulo 2^W; no overflow trap.
- mfhi/mflo:
  - Out = HI or LO register, combinational.
  - If Busy=1: Stall=1 and Out = stale register value.
- multu/divu:
  - Operands latched when Issue=1 and FSM is IDLE.
  - Operands are RD1 and RD2; ALUSrc is ignored.
  - Out is don't-care and driven 0 in that cycle.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL/DIV on an accepted multu/divu; counter loads W.
  - MUL/DIV: one shift-add (restoring shift-subtract for DIV) per cycle; counter decrements each cycle.
  - At counter==1, the next edge writes HI/LO and returns to IDLE; Done=1 for exactly that following cycle.
- Latency: op accepted at edge k.
  - Busy=1 for cycles k+1 .. k+W.
  - HI/LO written at edge k+W.
  - Done=1 and Busy=0 in cycle k+W+1.
- multu result: {HI,LO} = full 2W-bit product.
- divu result: LO = quotient, HI = remainder.
- Divide by zero: completes in normal latency with LO = all ones, HI = dividend. No exception.
- multu/divu issued while Busy=1: Stall=1, not accepted. It is accepted on the first cycle Busy=0 if still presented.
- Done and a new accepted op in the same cycle: legal; the new op starts and HI/LO already hold the previous result.
- Stall is combinational: Issue & Busy & (mul/div/mfhi/mflo).
- Stall is never asserted for plain ALU ops.
- Reset values:
  - FSM=IDLE; HI=0, LO=0; counter=0; Busy=0, Done=0.
  - Out follows the combinational path; with all inputs 0, Out=0 and Zero=1.
- Reset mid-operation aborts the iteration. HI/LO are cleared to 0 and Done is not pulsed.

Decomposition:
- Shared package alu_pkg:
  - ALUop encodings.
  - Funct localparams (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_MULTU, FN_DIVU, FN_MFHI, FN_MFLO).
  - FSM state enum.
- One sub-module, muldiv_iter:
  - Holds the FSM, counter, shift registers and HI/LO.
  - Handshake to parent: start, op, a, b -> busy, done, hi, lo.
- Combinational ALU and decode stay in the top module.

Test Plan (W=32):
- ALUop=10, RD1=5, RD2=6, funct add/sub/and/or/slt/nor -> Out = 11 / 0xFFFFFFFF / 4 / 7 / 1 / 0xFFFFFFF8; Zero=0 throughout; Out2=6.
- ALUop=01, RD1=RD2=9 -> Out=0, Zero=1. ALUop=00, ALUSrc=1, RD1=100, SE=0xFFFFFFFC -> Out=96.
- multu RD1=0x00010000, RD2=0x00010000 issued at edge k:
  - Busy=1 for 32 cycles; Done pulses in cycle k+33.
  - Then mfhi -> 1, mflo -> 0.
  - mfhi issued during Busy -> Stall=1 every cycle until Done.
- divu RD1=100, RD2=7 -> after Done, LO=14, HI=2. divu RD1=100, RD2=0 -> LO=0xFFFFFFFF, HI=100.
- Back-to-back: second multu (3*4) held at Issue during Busy:
  - Stall=1 until the first op completes; accepted in the Done cycle.
  - After its own 32 cycles, LO=12, HI=0.
- Reset asserted 10 cycles into a multu -> next cycle Busy=0, Done=0, HI=LO=0; a following multu 2*3 yields LO=6.
